div8_seq: RTL
=============

DIV8_SEQ -- requirements
Module: div8_seq

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock; all state changes on this edge.
REQ-002 SHALL have port: rst_n  input  1  reset; one clock, reset synchronous and active-low.
REQ-003 SHALL have port: in_valid  input  1  dividend/divisor valid.
REQ-004 SHALL have port: in_ready  output  1  block able to accept operands.
REQ-005 SHALL have port: dividend  input  16  unsigned dividend, e.g. a mul8 product.
REQ-006 SHALL have port: divisor  input  8  unsigned divisor.
REQ-007 SHALL have port: out_valid  output  1  result valid.
REQ-008 SHALL have port: out_ready  input  1  consumer takes result.
REQ-009 SHALL have port: quotient  output  8  unsigned quotient.
REQ-010 SHALL have port: remainder  output  8  unsigned remainder.
REQ-011 SHALL have port: dz  output  1  divide-by-zero flag.
REQ-012 SHALL have port: ovf  output  1  quotient-overflow flag: dividend[15:8] >= divisor, divisor nonzero.

Function
REQ-013 SHALL use states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-014 Accept SHALL occur on a clk edge with in_valid & in_ready; operands are registered; state -> CALC with iteration counter = 0.
REQ-015 CALC SHALL run restoring division, one quotient bit per cycle, MSB first, over exactly 8 cycles; 9-bit partial remainder so no carry is lost.
REQ-016 After the 8th CALC cycle, state SHALL -> DONE and out_valid = 1; normal latency is accept edge + 9 edges to out_valid high.
REQ-017 In DONE, quotient/remainder/dz/ovf SHALL hold stable until out_valid & out_ready; that edge returns the block to IDLE with out_valid = 0.
REQ-018 in_ready SHALL be 0 during DONE; no new accept on the result-handover edge; next accept earliest one edge later.
REQ-019 Operand input changes while not in IDLE SHALL have no effect.
REQ-020 For normal operands: dividend = quotient*divisor + remainder, remainder < divisor, dz = ovf = 0.
REQ-021 divisor = 0: dz = 1, ovf = 0, quotient = 8'hFF, remainder = dividend[7:0].
REQ-022 ovf case: ovf = 1, dz = 0, quotient = 8'hFF, remainder = dividend[7:0].
REQ-023 Outputs SHALL be registered; no combinational path from inputs to quotient/remainder/dz/ovf/out_valid.

Reset
REQ-024 rst_n low on a clk edge SHALL force IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, dz = 0, ovf = 0, counter = 0, from any state.
REQ-025 Reset mid-CALC or in DONE SHALL discard the in-flight result; no out_valid pulse follows reset release.
REQ-026 An in_valid asserted in the same cycle as rst_n low SHALL not be accepted.

Configuration
REQ-027 Macro DIV8_SEQ_FAST_EN defined: dz and ovf cases SHALL be detected at accept and go straight to DONE; out_valid is high 1 edge after accept.
REQ-028 Macro DIV8_SEQ_FAST_EN undefined: dz and ovf cases SHALL still pass through all 8 CALC cycles; 9-edge latency; output values per REQ-021/022 in both builds.

Verification
REQ-029 Normal case: dividend 16'h1234, divisor 8'h56 -> quotient 8'h36, remainder 8'h10, dz = ovf = 0, out_valid 9 edges after accept.
REQ-030 Boundary case: dividend 16'h00FF, divisor 8'h01 -> quotient 8'hFF, remainder 0, ovf = 0; dividend 16'h0100, divisor 8'h01 -> ovf = 1, quotient 8'hFF, remainder 8'h00.
REQ-031 Divide by zero: dividend 16'hABCD, divisor 0 -> dz = 1, quotient 8'hFF, remainder 8'hCD; latency 1 with DIV8_SEQ_FAST_EN, 9 without.
REQ-032 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> outputs stable and in_ready = 0 throughout; release -> IDLE next edge.
REQ-033 Reset: assert rst_n = 0 at CALC cycle 4 -> next edge IDLE with all outputs 0; a fresh 16'h1234 / 8'h56 then completes correctly.
REQ-034 Random sweep: 10k random operands, both macro builds -> all results match the software model per REQ-020/021/022.

Source files
------------

// File: rtl/div8_seq.sv
// div8_seq: sequential 16/8 unsigned restoring divider producing an 8-bit
// quotient and an 8-bit remainder, with a valid/ready handshake on each side.
// Build option: define DIV8_SEQ_FAST_EN to send divide-by-zero and
// quotient-overflow operands straight to DONE at accept, skipping the 8
// CALC cycles.
module div8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        dz,
  output logic        ovf
);

  localparam int unsigned DSR_W = 8;
  localparam int unsigned PR_W  = DSR_W + 1;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DSR_W-1:0]   pr_q, pr_d;        // restored partial remainder
  logic [DSR_W-1:0]   lo_q, lo_d;        // low dividend byte, rotated MSB first
  logic [DSR_W-1:0]   dsr_q, dsr_d;
  logic [DSR_W-1:0]   quot_q, quot_d;
  logic               op_dz_q, op_dz_d;
  logic               op_ovf_q, op_ovf_d;
  logic [DSR_W-1:0]   quotient_q, quotient_d;
  logic [DSR_W-1:0]   remainder_q, remainder_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [PR_W-1:0]    shifted;
  logic               ge;
  logic [DSR_W-1:0]   pr_next;
  logic [DSR_W-1:0]   quot_next;
  logic [DSR_W-1:0]   lo_rot;
  logic               acc_dz;
  logic               acc_ovf;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted   = {pr_q, lo_q[DSR_W-1]};
    ge        = (shifted >= {1'b0, dsr_q});
    pr_next   = ge ? DSR_W'(shifted - {1'b0, dsr_q}) : shifted[DSR_W-1:0];
    quot_next = {quot_q[DSR_W-2:0], ge};
    lo_rot    = {lo_q[DSR_W-2:0], lo_q[DSR_W-1]};
    acc_dz    = (divisor == '0);
    acc_ovf   = !acc_dz && (dividend[15:8] >= divisor);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pr_d        = pr_q;
    lo_d        = lo_q;
    dsr_d       = dsr_q;
    quot_d      = quot_q;
    op_dz_d     = op_dz_q;
    op_ovf_d    = op_ovf_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          dsr_d    = divisor;
          pr_d     = dividend[15:8];
          lo_d     = dividend[7:0];
          quot_d   = '0;
          cnt_d    = '0;
          op_dz_d  = acc_dz;
          op_ovf_d = acc_ovf;
`ifdef DIV8_SEQ_FAST_EN
          if (acc_dz || acc_ovf) begin
            state_d     = DONE;
            quotient_d  = 8'hFF;
            remainder_d = dividend[7:0];
            dz_d        = acc_dz;
            ovf_d       = acc_ovf;
          end else begin
            state_d = CALC;
          end
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        pr_d   = pr_next;
        lo_d   = lo_rot;
        quot_d = quot_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(7)) begin
          // After 8 rotations lo_rot is the original low dividend byte again.
          state_d     = DONE;
          quotient_d  = (op_dz_q || op_ovf_q) ? 8'hFF : quot_next;
          remainder_d = (op_dz_q || op_ovf_q) ? lo_rot : pr_next;
          dz_d        = op_dz_q;
          ovf_d       = op_ovf_q;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pr_q        <= '0;
      lo_q        <= '0;
      dsr_q       <= '0;
      quot_q      <= '0;
      op_dz_q     <= 1'b0;
      op_ovf_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pr_q        <= pr_d;
      lo_q        <= lo_d;
      dsr_q       <= dsr_d;
      quot_q      <= quot_d;
      op_dz_q     <= op_dz_d;
      op_ovf_q    <= op_ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule
